// File: rtl/osc_trig_pkg.sv
// Shared types and constants for the scope edge-trigger engine.
package osc_trig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SEEK_ARM,
    ST_SEEK_FIRE,
    ST_HOLD
  } trig_state_t;

  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;

  // Pre-trigger / holdoff sample counter and auto-trigger timeout widths.
  localparam int unsigned CNT_W = 16;
  localparam int unsigned TMO_W = 20;

endpackage

// File: rtl/trig_detect_thresh.sv
// Saturating hysteresis thresholds around the trigger level plus the
// arm (leave the band on the far side) and fire (cross the level) compares.
module trig_thresh
  import osc_trig_pkg::*;
#(
  parameter int unsigned HYST = 4
) (
  input  logic [7:0] level,
  input  logic       edge_sel,
  input  logic [7:0] sample,
  output logic       arm_hit,
  output logic       fire_hit
);

  localparam logic [8:0] HYST_W = 9'(HYST);

  logic [8:0] sum;
  logic [7:0] lo;
  logic [7:0] hi;

  always_comb begin
    sum = {1'b0, level} + HYST_W;
    lo  = ({1'b0, level} >= HYST_W) ? (level - HYST_W[7:0]) : '0;
    hi  = sum[8] ? '1 : sum[7:0];
  end

  always_comb begin
    if (edge_sel == EDGE_RISE) begin
      arm_hit  = (sample <= lo);
      fire_hit = (sample >= level);
    end else begin
      arm_hit  = (sample >= hi);
      fire_hit = (sample <= level);
    end
  end

endmodule

// File: rtl/trig_detect.sv
// Edge-trigger FSM: arm -> pre-trigger fill -> hysteresis seek -> holdoff.
// Optional auto-trigger timeout is built when TRIG_AUTO_EN is defined.
module trig_detect
  import osc_trig_pkg::*;
#(
  parameter int unsigned HYST         = 4,
  parameter int unsigned PRE_DEPTH    = 150,
  parameter int unsigned HOLDOFF      = 16,
  parameter int unsigned AUTO_TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ad_data,
  input  logic       deci_valid,
  input  logic [7:0] trig_level,
  input  logic       trig_edge,
  input  logic       wave_run,
  input  logic       arm,
  output logic       trig_pulse,
  output logic       trig_busy,
  output logic       auto_trig
);

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_DEPTH - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);

  trig_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       level_q, level_n;
  logic             edge_q, edge_n;
  logic             pulse_q, pulse_n;
  logic             auto_q, auto_n;
  logic             arm_hit, fire_hit;

`ifdef TRIG_AUTO_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(AUTO_TIMEOUT - 1);
  logic [TMO_W-1:0] tmo, tmo_n;
`endif

  trig_thresh #(
    .HYST(HYST)
  ) u_thresh (
    .level   (level_q),
    .edge_sel(edge_q),
    .sample  (ad_data),
    .arm_hit (arm_hit),
    .fire_hit(fire_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      level_q <= '0;
      edge_q  <= EDGE_RISE;
      pulse_q <= 1'b0;
      auto_q  <= 1'b0;
`ifdef TRIG_AUTO_EN
      tmo     <= '0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      level_q <= level_n;
      edge_q  <= edge_n;
      pulse_q <= pulse_n;
      auto_q  <= auto_n;
`ifdef TRIG_AUTO_EN
      tmo     <= tmo_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    level_n = level_q;
    edge_n  = edge_q;
    pulse_n = 1'b0;
    auto_n  = 1'b0;
`ifdef TRIG_AUTO_EN
    tmo_n   = tmo;
`endif

    unique case (state)
      ST_IDLE: begin
        if (arm && wave_run) begin
          level_n = trig_level;
          edge_n  = trig_edge;
          cnt_n   = '0;
          state_n = ST_PRE;
        end
      end
      ST_PRE: begin
        if (deci_valid) begin
          if (cnt == PRE_LAST) begin
            cnt_n   = '0;
            state_n = ST_SEEK_ARM;
`ifdef TRIG_AUTO_EN
            tmo_n   = '0;
`endif
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      ST_SEEK_ARM: begin
        if (deci_valid && arm_hit) state_n = ST_SEEK_FIRE;
      end
      ST_SEEK_FIRE: begin
        if (deci_valid && fire_hit) begin
          pulse_n = 1'b1;
          cnt_n   = '0;
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (HOLDOFF == 0) begin
          state_n = ST_IDLE;
        end else if (deci_valid) begin
          if (cnt == HOLD_LAST) begin
            cnt_n   = '0;
            state_n = ST_IDLE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase

`ifdef TRIG_AUTO_EN
    // Timeout overrides the search result unless a real edge fired on this sample.
    if ((state == ST_SEEK_ARM || state == ST_SEEK_FIRE) && deci_valid) begin
      tmo_n = tmo + TMO_W'(1);
      if (tmo == TMO_LAST && !pulse_n) begin
        pulse_n = 1'b1;
        auto_n  = 1'b1;
        cnt_n   = '0;
        state_n = ST_HOLD;
      end
    end
`endif

    // Stop wins over everything, including a pulse due this cycle.
    if (!wave_run) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      pulse_n = 1'b0;
      auto_n  = 1'b0;
`ifdef TRIG_AUTO_EN
      tmo_n   = '0;
`endif
    end
  end

  assign trig_pulse = pulse_q;
  assign trig_busy  = (state != ST_IDLE);
  assign auto_trig  = auto_q;

endmodule

// File: doc/trig_detect.md
Name: trig_detect

Overview:
- Edge-trigger engine for the scope capture path, in the AD sample clock domain.
- Upstream of data_store: consumes raw AD samples qualified by the decimator's deci_valid, plus the trigger settings from the Avalon config block.
- Emits a one-cycle trigger pulse that data_store uses to freeze its pre/post-trigger window.
- Adds hysteresis against noise, a pre-trigger fill wait, holdoff after each trigger and, optionally, an auto-trigger timeout.

Parameters:
HYST, 4, hysteresis band in AD codes (8-bit unsigned)
PRE_DEPTH, 150, decimated samples required after arm before a trigger may fire
HOLDOFF, 16, decimated samples ignored after a trigger before returning to IDLE
AUTO_TIMEOUT, 1000000, decimated samples searched before a forced trigger (20-bit counter)

Ports:
clk  in  1  AD sample clock (25 MHz)
rst  in  1  synchronous reset, active-high
ad_data  in  8  AD sample, unsigned
deci_valid  in  1  sample strobe from decimator
trig_level  in  8  trigger level code
trig_edge  in  1  1 = rising, 0 = falling
wave_run  in  1  capture enable; 0 = stop
arm  in  1  one-cycle request from data_store to start a new search
trig_pulse  out  1  one-cycle trigger strobe
trig_busy  out  1  high in any state other than IDLE
auto_trig  out  1  qualifies trig_pulse as forced (timeout)

Behaviour:
- Reset: state IDLE; all counters 0; trig_pulse = 0, trig_busy = 0, auto_trig = 0; latched level = 0, latched edge = 1.
- Samples and counters advance only on cycles with deci_valid = 1. Outputs are registered: trig_pulse asserts the cycle after the qualifying deci_valid cycle.
- Thresholds are computed from the latched level with saturating 8-bit arithmetic:
  - lo = max(level − HYST, 0)
  - hi = min(level + HYST, 255)
- IDLE: on arm = 1 and wave_run = 1, latch trig_level and trig_edge, clear the sample counter, go to PRE. arm while not in IDLE is ignored.
- PRE: count deci samples; when the count reaches PRE_DEPTH − 1 on a deci_valid cycle, go to SEEK_ARM.
- SEEK_ARM:
  - Rising: wait for a sample ≤ lo.
  - Falling: wait for a sample ≥ hi.
  - On that sample, go to SEEK_FIRE.
- SEEK_FIRE:
  - Rising: fire on a sample ≥ level.
  - Falling: fire on a sample ≤ level.
  - Firing pulses trig_pulse, clears the counter and goes to HOLD. A sample that only re-enters the arm band does not return to SEEK_ARM.
- HOLD: count HOLDOFF deci samples, then go to IDLE. With HOLDOFF = 0, go to IDLE on the next cycle.
- wave_run = 0 in any state: go to IDLE on the next edge and suppress any pulse due in the same cycle (stop wins over fire). Counters clear.
- Changes to trig_level or trig_edge after the IDLE→PRE transition have no effect until the next arm.
- rst mid-search: immediate return to the reset state; no pulse.
- auto_trig is valid only while trig_pulse = 1 and is 0 otherwise.

Optional Feature:
- Macro TRIG_AUTO_EN.
- Defined:
  - A 20-bit timeout counter clears on entry to SEEK_ARM and counts deci samples in SEEK_ARM and SEEK_FIRE.
  - When it reaches AUTO_TIMEOUT − 1, force trig_pulse = 1 with auto_trig = 1 and go to HOLD.
  - A real edge on the same sample as the timeout wins: auto_trig = 0.
- Undefined: no timeout counter; searching waits indefinitely; auto_trig is tied to 0.

Decomposition:
- Package osc_trig_pkg holds:
  - the state encoding (IDLE, PRE, SEEK_ARM, SEEK_FIRE, HOLD)
  - the edge constants EDGE_RISE = 1 and EDGE_FALL = 0
  - the counter width constants
- One sub-module, trig_thresh: combinational saturating lo/hi generator plus the arm/fire comparators. Inputs: level, edge, sample. Outputs: arm_hit, fire_hit.
- The FSM and counters stay in trig_detect.

Test Plan:
1. Rising edge, level 128, HYST 4, PRE_DEPTH 4, deci_valid every cycle, arm, ramp 100→160 step 1 → trig_pulse exactly once, the cycle after sample 128; auto_trig = 0.
2. Noise rejection, rising, level 128: samples toggling 126/130 with no sample ≤ 124 → no pulse. Then inject 120 followed by 130 → one pulse after the 130 sample.
3. Saturation, falling, level 253, HYST 4: hi = 255. Samples 255 then 250 → pulse after 250. Level 2 rising: lo = 0, fires after 0 then 2.
4. Sequencing: arm during PRE/HOLD ignored; trig_busy high from the cycle after arm until HOLD ends (HOLDOFF = 16 deci samples); with deci_valid every 4th cycle, all counts follow deci_valid only.
5. wave_run deasserted on the fire-sample cycle → no pulse, IDLE next cycle, trig_busy = 0; rst asserted mid-SEEK_FIRE → all outputs 0 the next cycle.
6. TRIG_AUTO_EN defined, AUTO_TIMEOUT 8, constant input 50 at level 128 → pulse with auto_trig = 1 after the 8th search sample; undefined → no pulse after 100 samples.
